// File: rtl/fetch_memory_unit.sv
// Instruction fetch unit: a small user-loadable memory plus a fetch FSM that hands opcodes downstream.
// Optional breakpoint-to-halt logic is compiled in by defining FETCH_BREAKPOINT_EN.
module fetch_memory_unit #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 4,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] user_address,
    input  logic              write_memory,
    input  logic              opcode_ready,
    input  logic              bp_enable,
    input  logic [ADDR_W-1:0] bp_address,
    output logic [DATA_W-1:0] opcode,
    output logic              opcode_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              memory_enable,
    output logic              opcode_reg_load,
    output logic              halted,
    output logic              bp_hit
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] mem_words [DEPTH];
    logic [DATA_W-1:0] mem_rd;
    logic              user_wr;

    // Writes are only honoured in load mode; run mode owns the memory.
    assign user_wr = write_memory & ~op;

    // The memory must clear on reset, so each word is its own register.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_q <= '0;
            end else if (user_wr && (user_address == ADDR_W'(gi))) begin
                word_q <= data_in;
            end
        end

        assign mem_words[gi] = word_q;
    end

    assign mem_rd = mem_words[pc_q];

`ifdef FETCH_BREAKPOINT_EN
    logic bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp = bp_enable ^ (^bp_address);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            opcode_q <= '0;
`ifdef FETCH_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
        end else if (!op) begin
            // Leaving run mode abandons any pending opcode; opcode itself is kept.
            state_q  <= S_IDLE;
            pc_q     <= '0;
`ifdef FETCH_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
`ifdef FETCH_BREAKPOINT_EN
                    if (bp_enable && (pc_q == bp_address)) begin
                        state_q  <= S_HALT;
                        bp_hit_q <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                    end
`else
                    state_q <= S_LOAD;
`endif
                end
                S_LOAD: begin
                    opcode_q <= mem_rd;
                    pc_q     <= pc_q + 1'b1;
                    state_q  <= (mem_rd == HALT_OPCODE) ? S_HALT : S_VALID;
                end
                S_VALID: begin
                    if (opcode_ready) begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign opcode          = opcode_q;
    assign pc              = pc_q;
    assign memory_enable   = (state_q == S_FETCH);
    assign opcode_reg_load = (state_q == S_LOAD);
    assign opcode_valid    = (state_q == S_VALID);
    assign halted          = (state_q == S_HALT);
`ifdef FETCH_BREAKPOINT_EN
    assign bp_hit          = bp_hit_q;
`else
    assign bp_hit          = 1'b0;
`endif

endmodule
